// File: rtl/delay_counter.sv
// Microsecond delay timer: while start is held, counts CLOCK_SPEED_MHZ*US_DELAY cycles then holds out high.
// Optional one-cycle terminal strobe on pulse when DELAY_COUNTER_PULSE_EN is defined.
module delay_counter #(
    parameter int unsigned CLOCK_SPEED_MHZ = 12,
    parameter int unsigned US_DELAY        = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
`ifdef DELAY_COUNTER_PULSE_EN
    output logic pulse,
`endif
    output logic out
);

    localparam int unsigned DELAY_CYCLES = CLOCK_SPEED_MHZ * US_DELAY;
    localparam int unsigned CNT_W        = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TERM  = CNT_W'(DELAY_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_expired;
    logic             w_hit;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_expired = (r_cnt == C_TERM);
    // Only meaningful while counting; w_cnt_inc cannot overflow below C_TERM.
    assign w_hit     = (w_cnt_inc == C_TERM);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (!start) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (!w_expired) begin
            r_cnt <= w_cnt_inc;
            if (w_hit)
                r_out <= 1'b1;
        end
    end

    assign out = r_out;

`ifdef DELAY_COUNTER_PULSE_EN
    logic r_pulse;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_pulse <= 1'b0;
        else if (!start)
            r_pulse <= 1'b0;
        else
            r_pulse <= !w_expired && w_hit;
    end

    assign pulse = r_pulse;
`endif

endmodule

// File: tb/tb_delay_counter.sv
// Directed bench for delay_counter: default 24-cycle instance plus a 1-cycle boundary instance.
module tb_delay_counter;

    logic CLK;
    logic RST;
    logic start;
    logic out_a;
    logic out_b;
`ifdef DELAY_COUNTER_PULSE_EN
    logic pulse_a;
    logic pulse_b;
`endif

    int unsigned errors;
    int unsigned checks;

    delay_counter #(
        .CLOCK_SPEED_MHZ(12),
        .US_DELAY       (2)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .start(start),
`ifdef DELAY_COUNTER_PULSE_EN
        .pulse(pulse_a),
`endif
        .out  (out_a)
    );

    delay_counter #(
        .CLOCK_SPEED_MHZ(1),
        .US_DELAY       (1)
    ) dut_one (
        .CLK  (CLK),
        .RST  (RST),
        .start(start),
`ifdef DELAY_COUNTER_PULSE_EN
        .pulse(pulse_b),
`endif
        .out  (out_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Run n edges with start high, expecting out to rise exactly after edge n.
    task automatic full_delay(input string tag, input int unsigned n);
        for (int unsigned k = 1; k <= n; k++) begin
            tick();
            chk(tag, {31'b0, out_a}, {31'b0, (k >= n)});
`ifdef DELAY_COUNTER_PULSE_EN
            chk({tag, "_pulse"}, {31'b0, pulse_a}, {31'b0, (k == n)});
`endif
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST    = 1'b1;
        start  = 1'b1;

        // Reset holds everything low even with start high.
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("rst_out", {31'b0, out_a}, 32'd0);
            chk("rst_out_one", {31'b0, out_b}, 32'd0);
            chk("rst_cnt", {27'b0, dut.r_cnt}, 32'd0);
`ifdef DELAY_COUNTER_PULSE_EN
            chk("rst_pulse", {31'b0, pulse_a}, 32'd0);
`endif
        end

        // Release reset between edges; next edge is edge 1.
        RST = 1'b0;
        tick();
        chk("nominal_e1", {31'b0, out_a}, 32'd0);
        chk("one_cycle_e1", {31'b0, out_b}, 32'd1);
`ifdef DELAY_COUNTER_PULSE_EN
        chk("one_cycle_pulse_e1", {31'b0, pulse_b}, 32'd1);
`endif
        for (int unsigned k = 2; k <= 24; k++) begin
            tick();
            chk("nominal", {31'b0, out_a}, {31'b0, (k >= 24)});
        end
        chk("nominal_cnt", {27'b0, dut.r_cnt}, 32'd24);
`ifdef DELAY_COUNTER_PULSE_EN
        chk("one_cycle_pulse_e24", {31'b0, pulse_b}, 32'd0);
`endif

        // Saturation: 50 more cycles held high.
        for (int unsigned i = 0; i < 50; i++) begin
            tick();
            chk("sat_out", {31'b0, out_a}, 32'd1);
            chk("sat_cnt", {27'b0, dut.r_cnt}, 32'd24);
`ifdef DELAY_COUNTER_PULSE_EN
            chk("sat_pulse", {31'b0, pulse_a}, 32'd0);
`endif
        end
        chk("sat_out_one", {31'b0, out_b}, 32'd1);

        // Drop start: out falls at the first edge sampling it low.
        start = 1'b0;
        tick();
        chk("drop_out", {31'b0, out_a}, 32'd0);
        chk("drop_cnt", {27'b0, dut.r_cnt}, 32'd0);
        chk("drop_out_one", {31'b0, out_b}, 32'd0);

        // Abort after 10 counting cycles, then a fresh full delay.
        start = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            chk("abort_pre", {31'b0, out_a}, 32'd0);
        end
        chk("abort_pre_cnt", {27'b0, dut.r_cnt}, 32'd10);
        start = 1'b0;
        tick();
        chk("abort_cnt", {27'b0, dut.r_cnt}, 32'd0);
        start = 1'b1;
        full_delay("restart", 24);

        // Release one cycle after expiry, then re-arm for a full delay.
        tick();
        chk("hold_after_rise", {31'b0, out_a}, 32'd1);
        start = 1'b0;
        tick();
        chk("release_out", {31'b0, out_a}, 32'd0);
        start = 1'b1;
        full_delay("rearm", 24);

        // Asynchronous reset between edges at count 12.
        start = 1'b0;
        tick();
        start = 1'b1;
        for (int unsigned i = 0; i < 12; i++)
            tick();
        chk("pre_async_cnt", {27'b0, dut.r_cnt}, 32'd12);
        #3;
        RST = 1'b1;
        #1;
        chk("async_out", {31'b0, out_a}, 32'd0);
        chk("async_cnt", {27'b0, dut.r_cnt}, 32'd0);
        #2;
        RST = 1'b0;
        full_delay("post_async", 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
